// File: rtl/multi_barrel_shifter_mux_reg.sv
// Single-cycle rotate unit: dedicated right and left log-shifter networks,
// a direction mux, and one output register.
module multi_barrel_shifter_mux_reg #(
    parameter int unsigned N = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2**N-1:0]  A,
    input  logic [N-1:0]     AMT,
    input  logic             s,
    output logic [2**N-1:0]  Y
);

    localparam int unsigned W = 2**N;

    logic [W-1:0] rr [0:N];
    logic [W-1:0] rl [0:N];
    logic [W-1:0] y_c;

    assign rr[0] = A;
    assign rl[0] = A;

    // Stage k rotates by 2**k when AMT[k] is set, otherwise passes through.
    for (genvar k = 0; k < int'(N); k++) begin : g_stage
        localparam int unsigned SH = 2**k;

        assign rr[k+1] = AMT[k] ? {rr[k][SH-1:0], rr[k][W-1:SH]} : rr[k];
        assign rl[k+1] = AMT[k] ? {rl[k][W-SH-1:0], rl[k][W-1:W-SH]} : rl[k];
    end

    assign y_c = s ? rl[N] : rr[N];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            Y <= '0;
        end else begin
            Y <= y_c;
        end
    end

endmodule

// File: tb/tb_multi_barrel_shifter_mux_reg.sv
// Scoreboard bench for the rotate unit: 8-bit and 16-bit instances checked
// against a bit-index rotation model.
module tb_multi_barrel_shifter_mux_reg;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  a8 = '0;
    logic [2:0]  amt8 = '0;
    logic        s8 = 1'b0;
    logic [7:0]  y8;
    logic [15:0] a16 = '0;
    logic [3:0]  amt16 = '0;
    logic        s16 = 1'b0;
    logic [15:0] y16;

    int checks = 0;
    int errors = 0;

    logic [7:0]  q8  [$];
    logic [15:0] q16 [$];

    always #5 clk = ~clk;

    multi_barrel_shifter_mux_reg #(.N(3)) dut8 (
        .clk(clk), .reset_n(reset_n), .A(a8), .AMT(amt8), .s(s8), .Y(y8)
    );

    multi_barrel_shifter_mux_reg #(.N(4)) dut16 (
        .clk(clk), .reset_n(reset_n), .A(a16), .AMT(amt16), .s(s16), .Y(y16)
    );

    // Y[i] = A[(i+m) mod w] for right, A[(i-m) mod w] for left.
    function automatic logic [15:0] rot_ref(input logic [15:0] a, input int m,
                                            input bit left, input int w);
        logic [15:0] r;
        int src;
        r = '0;
        for (int i = 0; i < w; i++) begin
            src = left ? ((i - m) % w + w) % w : (i + m) % w;
            r[i] = a[src];
        end
        return r;
    endfunction

    // One operation per DUT per cycle; the expected result is queued at issue.
    task automatic issue(input bit rst, input logic [7:0] a, input int m, input bit sl,
                         input logic [15:0] b, input int mb, input bit slb);
        logic [15:0] e8;
        logic [15:0] e16;
        @(negedge clk);
        reset_n = rst;
        a8 = a;  amt8 = 3'(m);  s8 = sl;
        a16 = b; amt16 = 4'(mb); s16 = slb;
        e8  = rst ? rot_ref({8'h00, a}, m, sl, 8) : 16'h0;
        e16 = rst ? rot_ref(b, mb, slb, 16) : 16'h0;
        q8.push_back(e8[7:0]);
        q16.push_back(e16);
    endtask

    // Monitor: Y is valid every cycle once an operation has been issued.
    always @(posedge clk) begin
        #1;
        if (q8.size() > 0) begin
            logic [7:0] e;
            e = q8.pop_front();
            checks++;
            if (y8 !== e) begin
                errors++;
                $display("FAIL y8: got %h expected %h at %0t", y8, e, $time);
            end
        end
        if (q16.size() > 0) begin
            logic [15:0] e;
            e = q16.pop_front();
            checks++;
            if (y16 !== e) begin
                errors++;
                $display("FAIL y16: got %h expected %h at %0t", y16, e, $time);
            end
        end
    end

    initial begin
        logic [7:0]  ra;
        logic [15:0] rb;

        // Held in reset with live inputs: Y stays 0.
        for (int i = 0; i < 3; i++) issue(1'b0, 8'hD2, 0, 1'b0, 16'h8001, 0, 1'b0);
        checks++;
        if (y8 !== 8'h00) begin
            errors++;
            $display("FAIL reset_hold: got %h expected 00", y8);
        end
        issue(1'b1, 8'hD2, 0, 1'b0, 16'h8001, 1, 1'b0);

        // Sweeps; the 16-bit instance carries the wide-word cases alongside.
        for (int m = 0; m < 8; m++) issue(1'b1, 8'hD2, m, 1'b0, 16'h8001, 15, 1'b1);
        for (int m = 0; m < 8; m++) issue(1'b1, 8'hD2, m, 1'b1, 16'h8001, 2 * m, m[0]);

        // Left by m and right by 8-m on the same random word.
        for (int r = 0; r < 3; r++) begin
            ra = 8'($urandom);
            rb = 16'($urandom);
            issue(1'b1, ra, 0, 1'b1, rb, 0, 1'b1);
            issue(1'b1, ra, 0, 1'b0, rb, 0, 1'b0);
            for (int m = 1; m < 8; m++) begin
                issue(1'b1, ra, m, 1'b1, rb, m, 1'b1);
                issue(1'b1, ra, 8 - m, 1'b0, rb, 16 - m, 1'b0);
            end
        end

        // Back-to-back random operations.
        for (int i = 0; i < 40; i++)
            issue(1'b1, 8'($urandom), int'($urandom_range(0, 7)), 1'($urandom),
                  16'($urandom), int'($urandom_range(0, 15)), 1'($urandom));

        // Asynchronous reset between edges.
        issue(1'b1, 8'hD2, 3, 1'b1, 16'h8001, 1, 1'b0);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        checks++;
        if (y8 !== 8'h00 || y16 !== 16'h0000) begin
            errors++;
            $display("FAIL async_reset: got %h/%h expected 00/0000", y8, y16);
        end
        issue(1'b0, 8'hD2, 3, 1'b1, 16'h8001, 1, 1'b0);
        issue(1'b1, 8'hD2, 3, 1'b1, 16'h8001, 1, 1'b0);

        // Drain, bounded to a few cycles.
        for (int i = 0; i < 4 && (q8.size() > 0 || q16.size() > 0); i++) @(posedge clk);
        #2;
        checks++;
        if (q8.size() != 0 || q16.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d/%0d pending expected 0/0", q8.size(), q16.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
